// File: rtl/ocra_grad_sched.sv
// ocra_grad_sched: gradient playback scheduler for the OC1 DAC path.
// Walks gradient BRAM one update (X, Y, Z, Z2) per interval tick. Each word
// goes to the SPI serializer over valid/ready. When the serializer drains,
// one LDAC pulse latches all four channels together.
module ocra_grad_sched #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int INT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [ADDR_W-1:0] offset_i,
    input  logic [ADDR_W-1:0] length_i,
    input  logic [INT_W-1:0]  interval_i,
    output logic              bram_en_o,
    output logic [ADDR_W-1:0] bram_addr_o,
    input  logic [DATA_W-1:0] bram_data_i,
    output logic [DATA_W-1:0] ser_data_o,
    output logic [1:0]        ser_ch_o,
    output logic              ser_valid_o,
    input  logic              ser_ready_i,
    input  logic              ser_idle_i,
    output logic              ldac_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              underrun_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_FETCH, S_CAPTURE, S_SEND,
        S_DRAIN, S_LDAC, S_WAIT, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [INT_W-1:0]  INT_ONE  = INT_W'(1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;      // next BRAM address; words are contiguous
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_u;
    logic [1:0]        r_ch;
    logic [INT_W-1:0]  r_reload;
    logic [INT_W-1:0]  r_cnt;
    logic              r_pend;
    logic              r_bram_en;
    logic [ADDR_W-1:0] r_bram_addr;
    logic [DATA_W-1:0] r_ser_data;
    logic [1:0]        r_ser_ch;
    logic              r_ser_valid;
    logic              r_ldac;
    logic              r_busy;
    logic              r_done;
    logic              r_underrun;

    logic              w_run;
    logic              w_tick;
    logic [ADDR_W-1:0] w_u_next;

    // The timer only counts once playback has left START; its first tick
    // is implied by START itself.
    assign w_run    = (r_state inside {S_FETCH, S_CAPTURE, S_SEND, S_DRAIN, S_LDAC, S_WAIT});
    assign w_tick   = w_run && (r_cnt == '0);
    assign w_u_next = r_u + ADDR_ONE;

    // Interval down-counter: loaded in START, reloads itself on every tick.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the values from before the clock edge.
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == S_START) begin
            r_cnt <= r_reload;
        end else if (w_run) begin
            r_cnt <= (r_cnt == '0) ? r_reload : r_cnt - INT_ONE;
        end
    end

    // Playback FSM; all handshake and status outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_len       <= '0;
            r_u         <= '0;
            r_ch        <= '0;
            r_reload    <= '0;
            r_pend      <= 1'b0;
            r_bram_en   <= 1'b0;
            r_bram_addr <= '0;
            r_ser_data  <= '0;
            r_ser_ch    <= '0;
            r_ser_valid <= 1'b0;
            r_ldac      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_underrun  <= 1'b0;
        end else if (stop_i && (r_state != S_IDLE)) begin
            // Abort: no LDAC, no done; underrun is kept until the next start.
            r_state     <= S_IDLE;
            r_pend      <= 1'b0;
            r_bram_en   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_ldac      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // NOTE: single-cycle strobes default low here and are raised
            // only on the transition that needs them.
            r_bram_en <= 1'b0;
            r_ldac    <= 1'b0;
            r_done    <= 1'b0;

            // A tick outside WAIT means the update overran its slot.
            if (w_tick && (r_state != S_WAIT)) begin
                r_underrun <= 1'b1;
                r_pend     <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start_i && !stop_i) begin
                        r_ptr      <= offset_i;
                        r_len      <= length_i;
                        r_reload   <= (interval_i == '0) ? '0 : interval_i - INT_ONE;
                        r_underrun <= 1'b0;
                        r_pend     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    r_u  <= '0;
                    r_ch <= '0;
                    if (r_len == '0) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_bram_en   <= 1'b1;
                        r_bram_addr <= r_ptr;
                        r_ptr       <= r_ptr + ADDR_ONE;
                        r_state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_ser_data  <= bram_data_i;
                    r_ser_ch    <= r_ch;
                    r_ser_valid <= 1'b1;
                    r_state     <= S_SEND;
                end
                S_SEND: begin
                    if (ser_ready_i) begin
                        r_ser_valid <= 1'b0;
                        if (r_ch == 2'd3) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_ch        <= r_ch + 2'd1;
                            r_bram_en   <= 1'b1;
                            r_bram_addr <= r_ptr;
                            r_ptr       <= r_ptr + ADDR_ONE;
                            r_state     <= S_FETCH;
                        end
                    end
                end
                S_DRAIN: begin
                    if (ser_idle_i) begin
                        r_ldac  <= 1'b1;
                        r_state <= S_LDAC;
                    end
                end
                S_LDAC: begin
                    r_u <= w_u_next;
                    if (w_u_next == r_len) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_tick || r_pend) begin
                        r_pend      <= 1'b0;
                        r_ch        <= '0;
                        r_bram_en   <= 1'b1;
                        r_bram_addr <= r_ptr;
                        r_ptr       <= r_ptr + ADDR_ONE;
                        r_state     <= S_FETCH;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bram_en_o   = r_bram_en;
    assign bram_addr_o = r_bram_addr;
    assign ser_data_o  = r_ser_data;
    assign ser_ch_o    = r_ser_ch;
    assign ser_valid_o = r_ser_valid;
    assign ldac_o      = r_ldac;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign underrun_o  = r_underrun;

endmodule

// File: doc/ocra_grad_sched.md
# ocra_grad_sched

Playback scheduler for the OC1 gradient DAC path. It steps through gradient BRAM at a programmed update interval. Each update fetches four words (X, Y, Z, Z2), hands them one at a time to the SPI serializer over a valid/ready handshake, waits for the serializer to drain, then pulses LDAC so all four channels latch together. It sits between the AXI register bank (which supplies start/stop/offset/length/interval) and the BRAM read port and serializer.

## Interface
- `ADDR_W`, 14: BRAM word-address width; matches `grad_bram_offset_i`.
- `DATA_W`, 32: BRAM / serializer word width.
- `INT_W`, 16: width of the interval counter.

- `clk`  in  1: system clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start_i`  in  1: single-cycle pulse; begins playback; ignored while `busy_o`=1.
- `stop_i`  in  1: single-cycle pulse; aborts playback.
- `offset_i`  in  ADDR_W: BRAM address of the first word; sampled on start.
- `length_i`  in  ADDR_W: number of updates (4 words each); sampled on start.
- `interval_i`  in  INT_W: clock cycles between update starts; sampled on start.
- `bram_en_o`  out  1: BRAM read enable.
- `bram_addr_o`  out  ADDR_W: BRAM read address.
- `bram_data_i`  in  DATA_W: BRAM read data, valid exactly 1 cycle after `bram_en_o`.
- `ser_data_o`  out  DATA_W: word to the serializer.
- `ser_ch_o`  out  2: channel index (0=X, 1=Y, 2=Z, 3=Z2).
- `ser_valid_o`  out  1: word valid.
- `ser_ready_i`  in  1: serializer accepts when `ser_valid_o` and `ser_ready_i` are both high.
- `ser_idle_i`  in  1: serializer has shifted out all accepted words.
- `ldac_o`  out  1: single-cycle latch-all pulse to the DAC framing logic.
- `busy_o`  out  1: playback in progress.
- `done_o`  out  1: single-cycle pulse when playback ends normally.
- `underrun_o`  out  1: sticky; an interval tick arrived before the previous update completed.

## Operation
- **Reset values:** all outputs are 0 and the state is IDLE.
- **States:**
  - IDLE → START on `start_i`. START latches `offset_i`, `length_i` and `interval_i`, clears `underrun_o`, sets `busy_o`, and zeroes the update counter `u`.
  - If `length_i`=0, START → DONE. Otherwise START → FETCH.
  - FETCH: assert `bram_en_o` with `bram_addr_o` = offset + 4·u + ch, computed modulo 2^ADDR_W (wrap-around is allowed). → CAPTURE.
  - CAPTURE: register `bram_data_i` into `ser_data_o`, drive `ser_ch_o`=ch, assert `ser_valid_o`. → SEND.
  - SEND: hold data, channel and valid stable until the handshake. On handshake, drop `ser_valid_o` the next cycle. If ch<3, increment ch and go to FETCH. If ch=3, go to DRAIN.
  - DRAIN: wait for `ser_idle_i`=1, then go to LDAC.
  - LDAC: `ldac_o`=1 for one cycle; increment u. If u+1 = length, go to DONE; else go to WAIT.
  - WAIT: wait for the interval tick, then set ch=0 and go to FETCH.
  - DONE: `done_o`=1 for one cycle, `busy_o`←0. → IDLE.
- **Interval timer:**
  - Free-running down-counter, loaded with interval−1 in START. On reaching 0 it emits a tick and reloads.
  - Ticks occur every `interval_i` cycles. The first tick is implied in START, so update 0 starts immediately.
  - `interval_i`=0 is treated as 1.
- **Underrun:**
  - A tick that arrives in any state other than WAIT sets `underrun_o` and is remembered in a one-deep pending flag.
  - WAIT with the pending flag set proceeds immediately and clears the flag. Further ticks while the flag is pending are dropped; `underrun_o` stays set.
  - Playback continues; ordering and addresses are unaffected.
- **Stop:**
  - `stop_i` in any non-IDLE state goes to IDLE on the next edge. It deasserts `ser_valid_o` and `busy_o`, and issues no `ldac_o` and no `done_o`.
  - `underrun_o` holds its value until the next start.
- **Priority:** `rst` beats `stop_i`, which beats everything else. `start_i` and `stop_i` asserted together in IDLE: start is ignored.

## Timing
- Start-to-first-read latency: `start_i` at cycle 0 → START at cycle 1 → `bram_en_o` at cycle 2 → `ser_valid_o` at cycle 4.
- Per word, with `ser_ready_i` held high: FETCH, CAPTURE, SEND = 3 cycles, so 12 cycles for four words, plus DRAIN, plus 1 LDAC cycle.
- `ldac_o` is asserted the cycle after `ser_idle_i` is sampled high in DRAIN.
- With no underrun, update k begins its FETCH k·interval cycles after START.
- `done_o` is asserted the cycle after the final `ldac_o`.
- `busy_o` is 1 from the cycle after `start_i` through the `done_o` cycle inclusive.

## Test plan
- **Basic playback.** Reset; BRAM[100..107]=0xA0..0xA7; offset=100, length=2, interval=40, `ser_ready_i`=1, `ser_idle_i` asserted 5 cycles after each last word.
  - Words are delivered with ch 0,1,2,3,0,1,2,3.
  - Exactly two `ldac_o` pulses, starting 40 cycles apart.
  - One `done_o`; `underrun_o`=0.
- **Backpressure.** Hold `ser_ready_i` low for 7 cycles mid-word.
  - `ser_data_o`, `ser_ch_o` and `ser_valid_o` stay stable.
  - No word is lost or duplicated.
- **Underrun.** interval=8, length=3.
  - `underrun_o`=1 after the first update.
  - Three `ldac_o` pulses, back-to-back updates, correct addresses.
- **Wrap-around.** offset=0x3FFE, length=1.
  - Reads occur at 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- **Abort and edge cases.**
  - `stop_i` during DRAIN: no `ldac_o`, no `done_o`; `busy_o` falls the next cycle.
  - `start_i` while busy is ignored.
  - length=0: `done_o` 2 cycles after start, no BRAM read.
- **Reset mid-run.** Assert `rst` during SEND.
  - All outputs are 0 the next cycle.
  - A fresh start runs correctly.
